combat_referee: RTL and testbench

Synchronous combat controller between the sprite/collision logic and the display path of the two-player fighting game. It turns per-player hit levels into single damage events and applies fixed damage to each health register. It runs per-player invincibility windows counted in video frames and sequences the match through FIGHT and OVER until a restart. Health and bar-position outputs drive the health-bar box drawers directly; invincibility flags drive the sprite flash.

---
 rtl/combat_referee.sv | 136 +++++++++++++
 tb/tb_combat_referee.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/combat_referee.sv
// Two-player combat referee: hit edge detect, damage, frame-counted
// invincibility, FIGHT/OVER sequencing. Option: COMBAT_DOUBLE_KO_EN.
module combat_referee #(
  parameter int MAX_HEALTH = 400,
  parameter int DAMAGE     = 100,
  parameter int IFRAMES    = 60,
  parameter int SCREEN_W   = 640
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        p1_hit,
  input  logic        p2_hit,
  input  logic        restart,
  output logic [10:0] p1_health,
  output logic [10:0] p2_health,
  output logic [10:0] p2_bar_x,
  output logic        p1_invincible,
  output logic        p2_invincible,
  output logic        game_over,
  output logic [1:0]  winner
);

  localparam logic [10:0] HMAX = 11'(MAX_HEALTH);
  localparam logic [10:0] DMG  = 11'(DAMAGE);
  localparam logic [10:0] SW   = 11'(SCREEN_W);
  localparam logic [7:0]  IFR  = 8'(IFRAMES);

  typedef enum logic {FIGHT, OVER} state_t;

  state_t      state_q, state_d;
  logic        hist1_q, hist1_d;
  logic        hist2_q, hist2_d;
  logic [7:0]  cnt1_q, cnt1_d;
  logic [7:0]  cnt2_q, cnt2_d;
  logic [10:0] h1_q, h1_d;
  logic [10:0] h2_q, h2_d;
  logic [10:0] bar_q, bar_d;
  logic        over_q, over_d;
  logic [1:0]  win_q, win_d;

  logic inv1, inv2;
  logic rise1, rise2;
  logic acc1, acc2;

  assign inv1  = (cnt1_q != 8'd0);
  assign inv2  = (cnt2_q != 8'd0);
  assign rise1 = p1_hit & ~hist1_q;
  assign rise2 = p2_hit & ~hist2_q;
  assign acc2  = rise2 & ~inv2 & (state_q == FIGHT);
`ifdef COMBAT_DOUBLE_KO_EN
  assign acc1  = rise1 & ~inv1 & (state_q == FIGHT);
`else
  // P1's attack takes priority: a simultaneous hit on P1 is dropped
  assign acc1  = rise1 & ~inv1 & (state_q == FIGHT) & ~acc2;
`endif

  always_comb begin
    state_d = state_q;
    hist1_d = p1_hit;
    hist2_d = p2_hit;
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
    h1_d    = h1_q;
    h2_d    = h2_q;
    over_d  = over_q;
    win_d   = win_q;
    unique case (state_q)
      FIGHT: begin
        if (frame_tick && inv1) cnt1_d = cnt1_q - 8'd1;
        if (frame_tick && inv2) cnt2_d = cnt2_q - 8'd1;
        if (acc1) begin
          h1_d   = (h1_q > DMG) ? h1_q - DMG : 11'd0;
          cnt1_d = IFR;
        end
        if (acc2) begin
          h2_d   = (h2_q > DMG) ? h2_q - DMG : 11'd0;
          cnt2_d = IFR;
        end
        if (h1_d == 11'd0 || h2_d == 11'd0) begin
          state_d = OVER;
          over_d  = 1'b1;
          win_d   = {h1_d == 11'd0, h2_d == 11'd0};
        end
      end
      OVER: begin
        cnt1_d = 8'd0;
        cnt2_d = 8'd0;
        if (restart) begin
          state_d = FIGHT;
          h1_d    = HMAX;
          h2_d    = HMAX;
          over_d  = 1'b0;
          win_d   = 2'b00;
        end
      end
      default: state_d = FIGHT;
    endcase
    bar_d = SW - h2_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FIGHT;
      hist1_q <= 1'b0;
      hist2_q <= 1'b0;
      cnt1_q  <= 8'd0;
      cnt2_q  <= 8'd0;
      h1_q    <= HMAX;
      h2_q    <= HMAX;
      bar_q   <= SW - HMAX;
      over_q  <= 1'b0;
      win_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      hist1_q <= hist1_d;
      hist2_q <= hist2_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      h1_q    <= h1_d;
      h2_q    <= h2_d;
      bar_q   <= bar_d;
      over_q  <= over_d;
      win_q   <= win_d;
    end
  end

  assign p1_health     = h1_q;
  assign p2_health     = h2_q;
  assign p2_bar_x      = bar_q;
  assign p1_invincible = inv1;
  assign p2_invincible = inv2;
  assign game_over     = over_q;
  assign winner        = win_q;

endmodule

// File: tb/tb_combat_referee.sv
// Scoreboard bench for combat_referee: a behavioural match model
// predicts every cycle's outputs; a monitor compares after each edge.
module tb_combat_referee;

  localparam int MAXH = 400;
  localparam int DMG  = 100;
  localparam int IFR  = 60;
  localparam int SW   = 640;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        p1_hit = 1'b0;
  logic        p2_hit = 1'b0;
  logic        restart = 1'b0;
  logic [10:0] p1_health, p2_health, p2_bar_x;
  logic        p1_invincible, p2_invincible, game_over;
  logic [1:0]  winner;

  combat_referee dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .p1_hit(p1_hit), .p2_hit(p2_hit), .restart(restart),
    .p1_health(p1_health), .p2_health(p2_health),
    .p2_bar_x(p2_bar_x),
    .p1_invincible(p1_invincible),
    .p2_invincible(p2_invincible),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] h1;
    logic [10:0] h2;
    logic [10:0] bar;
    logic        i1;
    logic        i2;
    logic        go;
    logic [1:0]  w;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Match model: health in pixels, timers in frames, plain integers.
  int m_h1, m_h2, m_t1, m_t2, m_win;
  bit m_over, m_prev1, m_prev2;

  function automatic int hit_hp(int h);
    return (h - DMG < 0) ? 0 : h - DMG;
  endfunction

  task automatic model(input bit r, input bit tk, input bit a,
                       input bit b, input bit rs);
    bit r1, r2, a1, a2;
    if (r) begin
      m_h1 = MAXH; m_h2 = MAXH; m_t1 = 0; m_t2 = 0;
      m_over = 0; m_win = 0; m_prev1 = 0; m_prev2 = 0;
      return;
    end
    r1 = a && !m_prev1;
    r2 = b && !m_prev2;
    m_prev1 = a;
    m_prev2 = b;
    if (!m_over) begin
      a1 = r1 && (m_t1 == 0);
      a2 = r2 && (m_t2 == 0);
`ifndef COMBAT_DOUBLE_KO_EN
      if (a1 && a2) a1 = 0;
`endif
      if (tk && m_t1 > 0) m_t1--;
      if (tk && m_t2 > 0) m_t2--;
      if (a1) begin m_h1 = hit_hp(m_h1); m_t1 = IFR; end
      if (a2) begin m_h2 = hit_hp(m_h2); m_t2 = IFR; end
      if (m_h1 == 0 || m_h2 == 0) begin
        m_over = 1;
        m_win = (m_h2 == 0 ? 1 : 0) + (m_h1 == 0 ? 2 : 0);
      end
    end else begin
      m_t1 = 0;
      m_t2 = 0;
      if (rs) begin
        m_h1 = MAXH; m_h2 = MAXH; m_over = 0; m_win = 0;
      end
    end
  endtask

  task automatic step(input bit r, input bit tk, input bit a,
                      input bit b, input bit rs);
    exp_t e;
    @(negedge clk);
    rst = r; frame_tick = tk; p1_hit = a; p2_hit = b; restart = rs;
    model(r, tk, a, b, rs);
    e.h1  = 11'(m_h1);
    e.h2  = 11'(m_h2);
    e.bar = 11'(SW - m_h2);
    e.i1  = (m_t1 != 0);
    e.i2  = (m_t2 != 0);
    e.go  = m_over;
    e.w   = 2'(m_win);
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input int act, input int want);
    n_checks++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, want);
    end
  endtask

  initial begin : monitor
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {p1_health, p2_health, p2_bar_x, p1_invincible,
             p2_invincible, game_over, winner};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL scoreboard @%0t: got h1=%0d h2=%0d bar=%0d i=%b%b go=%b w=%b, expected h1=%0d h2=%0d bar=%0d i=%b%b go=%b w=%b",
                   $time, a.h1, a.h2, a.bar, a.i1, a.i2, a.go, a.w,
                   e.h1, e.h2, e.bar, e.i1, e.i2, e.go, e.w);
        end
      end
    end
  end

  initial begin : stim
    bit ra, rb;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (10) step(0, 0, 0, 0, 0);
    chk("reset_p1_health", int'(p1_health), 400);
    chk("reset_p2_health", int'(p2_health), 400);
    chk("reset_bar", int'(p2_bar_x), 240);
    chk("reset_winner", int'(winner), 0);

    // Held P2 hit: one damage event only
    repeat (50) step(0, 0, 0, 1, 0);
    chk("held_p2_health", int'(p2_health), 300);
    chk("held_bar", int'(p2_bar_x), 340);
    chk("held_inv", int'(p2_invincible), 1);
    repeat (3) begin
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0);
    end
    chk("inv_discard", int'(p2_health), 300);
    step(0, 0, 0, 0, 0);
    repeat (59) step(0, 1, 0, 0, 0);
    chk("inv_59_ticks", int'(p2_invincible), 1);
    step(0, 1, 0, 0, 0);
    chk("inv_60_ticks", int'(p2_invincible), 0);
    step(0, 0, 0, 1, 0);
    chk("second_hit", int'(p2_health), 200);
    step(0, 0, 0, 0, 0);

    // Four spaced hits on P1: saturate to 0 and end the match
    repeat (4) begin
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      repeat (60) step(0, 1, 0, 0, 0);
    end
    chk("ko_p1_health", int'(p1_health), 0);
    chk("ko_game_over", int'(game_over), 1);
    chk("ko_winner", int'(winner), 2);
    step(0, 0, 1, 1, 0);
    chk("over_ignores", int'(p2_health), 200);
    step(0, 0, 0, 0, 1);
    chk("restart_p1", int'(p1_health), 400);
    chk("restart_winner", int'(winner), 0);

    // Bring both to 100, then simultaneous hit
    repeat (3) begin
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      repeat (60) step(0, 1, 0, 0, 0);
    end
    chk("pre_ko_p1", int'(p1_health), 100);
    step(0, 0, 1, 1, 0);
`ifdef COMBAT_DOUBLE_KO_EN
    chk("dko_p1", int'(p1_health), 0);
    chk("dko_winner", int'(winner), 3);
`else
    chk("prio_p1", int'(p1_health), 100);
    chk("prio_winner", int'(winner), 1);
`endif
    chk("sim_p2", int'(p2_health), 0);
    step(0, 0, 0, 0, 1);

    // Reset mid-invincibility with a coincident tick
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("rst_p1", int'(p1_health), 400);
    chk("rst_inv", int'(p1_invincible), 0);
    step(0, 0, 0, 0, 1);
    chk("restart_in_fight", int'(p1_health), 400);

    // Randomised play
    ra = 0; rb = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(5) == 0) ra = ~ra;
      if ($urandom_range(5) == 0) rb = ~rb;
      step($urandom_range(499) == 0, $urandom_range(1) == 1, ra, rb,
           $urandom_range(19) == 0);
    end

    #5;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left, expected 0",
               exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
